// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg
//   Shared types and constants for the external SRAM bridge.
//   - state_t       : access sequencer states
//   - BASE_ADDR_DEF : byte address mapped to SRAM word 0
//   - word_of()     : byte address -> 17-bit 32-bit-word index
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

    // Offset from the base wraps modulo 2^32. The byte lane bits and
    // everything above the SRAM's word range are dropped, so an
    // out-of-range address aliases silently.
    function automatic logic [16:0] word_of(input logic [31:0] addr,
                                            input logic [31:0] base);
        return 17'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if
//   Memory-stage request/response bundle between the pipeline and the
//   SRAM bridge.
//   rd_en/wr_en : level requests, held until ready
//   address     : byte address
//   write_data  : store data
//   read_data   : load result
//   ready       : 0 = freeze the pipeline
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// sram_controller
//   Bridges one 32-bit word access to a 16-bit asynchronous SRAM
//   (256K x 16) as two half-word phases, low half first. Each phase is
//   held for WAIT_CYCLES+1 cycles. While an access is in flight, ready
//   is low so the pipeline freezes.
//   Ports:
//     clk, rst        : clock, synchronous active-low reset
//     bus (slave)     : memory-stage request/response
//     SRAM_DQ         : bidirectional data bus, driven only in write phases
//     SRAM_ADDR       : half-word address {word, hi}
//     SRAM_WE_N/OE_N  : strobes, active-low
//     SRAM_CE_N/UB_N/LB_N : tied low
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire         [15:0] SRAM_DQ,
    output logic        [17:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              op_wr;      // latched op: 1 = write
    logic [16:0]       word_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic              phase;      // LO or HI: SRAM is being strobed
    logic              last;       // final cycle of the current phase
    logic              drive_dq;
    logic [15:0]       dq_out;

    assign phase = (state == LO) || (state == HI);
    assign last  = (cnt == CNT_LAST);

    // Request fields are held by upstream until ready, but they are latched
    // anyway so the SRAM side never depends on upstream holding them steady.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_wr   <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_en || bus.wr_en) begin
                        op_wr   <= !bus.rd_en;    // read wins a collision
                        word_q  <= word_of(bus.address, BASE_ADDR);
                        wdata_q <= bus.write_data;
                        cnt     <= '0;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (last) begin
                        if (!op_wr) rdata_q[15:0] <= SRAM_DQ;
                        cnt   <= '0;
                        state <= HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HI: begin
                    if (last) begin
                        if (!op_wr) rdata_q[31:16] <= SRAM_DQ;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // One-cycle completion; requests still high here are the
                // ones just serviced, so never restart from DONE.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM pins decode directly from state so a reset edge releases the
    // bus in the very next cycle.
    assign SRAM_ADDR = phase ? {word_q, (state == HI)} : 18'd0;
    assign SRAM_WE_N = !(phase && op_wr);
    assign SRAM_OE_N = !(phase && !op_wr);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign drive_dq = phase && op_wr;
    assign dq_out   = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ  = drive_dq ? dq_out : 16'bz;

    assign bus.read_data = rdata_q;
    assign bus.ready     = ((state == IDLE) && !(bus.rd_en || bus.wr_en)) ||
                           (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
//   Two controllers (WAIT_CYCLES 1 and 3), each with its own behavioural
//   SRAM. The SRAM commits a write only when WE_N has been held low at one
//   address for a full phase, so an aborted phase leaves memory untouched.
//   Expected results come from a word-level reference memory.
module tb_sram_controller;
    import sram_controller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rd_en, wr_en;
    logic [1:0][31:0]  address, write_data, read_data;
    logic [1:0]        ready;
    logic [1:0][17:0]  s_addr;
    logic [1:0]        s_we_n, s_oe_n, s_ce_n, s_ub_n, s_lb_n;
    logic [1:0][15:0]  s_dq_in;

    // Behavioural SRAM contents; unwritten locations return a fixed pattern.
    logic [15:0] mem     [2][262144];
    logic        written [2][262144];
    logic [1:0][17:0] wr_addr_last;
    int          wr_run [2];

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] last_rd [2];
    logic [31:0] ref_mem [int];

    function automatic int wait_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [15:0] pat(input logic [17:0] a);
        return a[15:0] ^ 16'hA55A ^ {14'd0, a[17:16]};
    endfunction

    function automatic logic [15:0] model_hw(input int g, input logic [17:0] a);
        return written[g][a] ? mem[g][a] : pat(a);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 1 : 3;
        sram_controller_if bus ();
        wire [15:0] dq;

        assign bus.rd_en      = rd_en[g];
        assign bus.wr_en      = wr_en[g];
        assign bus.address    = address[g];
        assign bus.write_data = write_data[g];
        assign read_data[g]   = bus.read_data;
        assign ready[g]       = bus.ready;

        assign dq = (!s_oe_n[g] && s_we_n[g]) ? model_hw(g, s_addr[g]) : 16'bz;
        assign s_dq_in[g] = dq;

        sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus),
            .SRAM_DQ   (dq),
            .SRAM_ADDR (s_addr[g]),
            .SRAM_WE_N (s_we_n[g]),
            .SRAM_OE_N (s_oe_n[g]),
            .SRAM_CE_N (s_ce_n[g]),
            .SRAM_UB_N (s_ub_n[g]),
            .SRAM_LB_N (s_lb_n[g])
        );
    end

    // Write pulse must span a full phase at one address to take effect.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!s_we_n[g]) begin
                wr_run[g]       <= (s_addr[g] == wr_addr_last[g] && wr_run[g] > 0) ? wr_run[g] + 1 : 1;
                wr_addr_last[g] <= s_addr[g];
                if (((s_addr[g] == wr_addr_last[g] && wr_run[g] > 0) ? wr_run[g] + 1 : 1) == wait_of(g) + 1) begin
                    mem[g][s_addr[g]]     <= s_dq_in[g];
                    written[g][s_addr[g]] <= 1'b1;
                end
            end else begin
                wr_run[g] <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] word_idx(input logic [31:0] a);
        return 17'(((a - 32'd1024) / 4) % 131072);
    endfunction

    function automatic int key(input int g, input logic [16:0] w);
        return (g << 20) | int'(w);
    endfunction

    function automatic logic [31:0] ref_word(input int g, input logic [16:0] w);
        if (ref_mem.exists(key(g, w))) return ref_mem[key(g, w)];
        return {pat({w, 1'b1}), pat({w, 1'b0})};
    endfunction

    // Called just after a rising edge; returns just after the edge that
    // leaves DONE, with requests dropped.
    task automatic do_access(input int g, input bit is_rd, input logic [31:0] a,
                             input logic [31:0] d);
        int          w      = wait_of(g);
        logic [16:0] wd     = word_idx(a);
        int          low    = 0;
        int          lo_cnt = 0;
        int          hi_cnt = 0;
        int          bad_strobe = 0;
        bit          done   = 0;
        rd_en[g] = is_rd;
        wr_en[g] = !is_rd;
        address[g] = a;
        write_data[g] = d;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (ready[g]) done = 1;
            else begin
                low++;
                if (!(s_we_n[g] && s_oe_n[g])) begin
                    if (s_addr[g] == {wd, 1'b0}) lo_cnt++;
                    if (s_addr[g] == {wd, 1'b1}) hi_cnt++;
                end
                if (is_rd ? !s_we_n[g] : !s_oe_n[g]) bad_strobe++;
            end
        end
        check("timeout", 32'(done), 32'd1);
        check("ready_low_cycles", low, 2 * w + 3);
        check("lo_phase_len", lo_cnt, w + 1);
        check("hi_phase_len", hi_cnt, w + 1);
        check(is_rd ? "we_during_read" : "oe_during_write", bad_strobe, 0);
        if (is_rd) last_rd[g] = ref_word(g, wd);
        check("read_data", read_data[g], last_rd[g]);
        @(posedge clk);
        #1;
        rd_en[g] = 1'b0;
        wr_en[g] = 1'b0;
        if (!is_rd) begin
            ref_mem[key(g, wd)] = d;
            check("mem_lo", model_hw(g, {wd, 1'b0}), d[15:0]);
            check("mem_hi", model_hw(g, {wd, 1'b1}), d[31:16]);
        end
    endtask

    initial begin
        logic [31:0] old_w, new_w, a;
        logic [16:0] wd;
        bit          found;
        rd_en = '0;
        wr_en = '0;
        address = '0;
        write_data = '0;
        wr_run[0] = 0;
        wr_run[1] = 0;
        wr_addr_last = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        for (int i = 0; i < 262144; i++) begin
            written[0][i] = 1'b0;
            written[1][i] = 1'b0;
        end

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("rst_ready", 32'(ready[g]), 32'd1);
            check("rst_we_n", 32'(s_we_n[g]), 32'd1);
            check("rst_oe_n", 32'(s_oe_n[g]), 32'd1);
            check("rst_addr", 32'(s_addr[g]), 32'd0);
            check("rst_rdata", read_data[g], 32'd0);
            check("tied_low", {29'd0, s_ce_n[g], s_ub_n[g], s_lb_n[g]}, 32'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed: write/read, back-to-back, long wait states
        do_access(0, 1'b0, 32'd1024, 32'hDEADBEEF);
        check("model0", model_hw(0, 18'd0), 32'h0000BEEF);
        check("model1", model_hw(0, 18'd1), 32'h0000DEAD);
        do_access(0, 1'b1, 32'd1024, 32'h0);
        check("rd_deadbeef", read_data[0], 32'hDEADBEEF);
        do_access(0, 1'b0, 32'd1028, 32'h12345678);
        do_access(0, 1'b1, 32'd1028, 32'h0);
        check("rd_12345678", read_data[0], 32'h12345678);
        check("model2", model_hw(0, 18'd2), 32'h00005678);
        check("model3", model_hw(0, 18'd3), 32'h00001234);
        do_access(1, 1'b1, 32'd1032, 32'h0);

        // Reset during the HI phase of a write
        a = 32'd1040;
        wd = word_idx(a);
        old_w = ref_word(0, wd);
        new_w = 32'hCAFEF00D;
        wr_en[0] = 1'b1;
        address[0] = a;
        write_data[0] = new_w;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (s_addr[0] == {wd, 1'b1} && !s_we_n[0]) found = 1;
        end
        check("hi_phase_seen", 32'(found), 32'd1);
        rst = 1'b0;
        wr_en[0] = 1'b0;
        @(posedge clk);
        #1;
        check("abort_we_n", 32'(s_we_n[0]), 32'd1);
        check("abort_ready", 32'(ready[0]), 32'd1);
        check("abort_addr", 32'(s_addr[0]), 32'd0);
        check("abort_rdata", read_data[0], 32'd0);
        rst = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        ref_mem[key(0, wd)] = {old_w[31:16], new_w[15:0]};
        check("abort_mem_lo", model_hw(0, {wd, 1'b0}), new_w[15:0]);
        check("abort_mem_hi", model_hw(0, {wd, 1'b1}), old_w[31:16]);
        @(posedge clk);
        #1;

        // Idle: nothing moves
        do_access(0, 1'b1, 32'd1024, 32'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready[0]), 32'd1);
            check("idle_we_n", 32'(s_we_n[0]), 32'd1);
            check("idle_rdata", read_data[0], 32'hDEADBEEF);
        end
        @(posedge clk);
        #1;

        // Random traffic, including ignored byte bits and wrapped addresses
        for (int i = 0; i < 60; i++) begin
            int g = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom();
            else a = 32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            do_access(g, 1'($urandom_range(0, 1)), a, $urandom());
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Bridges the pipeline's memory stage to a 16-bit external asynchronous SRAM (256K×16). It accepts one 32-bit word read or write per request, splits it into two half-word SRAM phases with programmable wait states, and drops `ready` while busy so the rest of the pipeline freezes. Data memory sits downstream of the memory stage and replaces its internal array: read data feeds the memory-stage register, and `ready` feeds every pipeline register enable.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles each half-word phase is held (phase length = WAIT_CYCLES+1).
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-low (`rst`=0 resets at the next rising edge).
- `rd_en` in 1: word read request, level, held until `ready`.
- `wr_en` in 1: word write request, level, held until `ready`.
- `address` in 32: byte address (ALU result).
- `write_data` in 32: store data (Rm value).
- `read_data` out 32: registered load result.
- `ready` out 1: 1 = no access pending or access completing this cycle; 0 = freeze the pipeline.
- `SRAM_DQ` inout 16: data bus; driven only during write phases, else high-Z.
- `SRAM_ADDR` out 18: half-word address.
- `SRAM_WE_N` out 1: write strobe, active-low.
- `SRAM_OE_N` out 1: output enable, active-low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1: tied 0.

## Operation
- States: IDLE, LO, HI, DONE; a wait counter of width ≥ clog2(WAIT_CYCLES+1) runs within LO and HI.
- IDLE: if `rd_en|wr_en`, latch op (read wins if both; both asserted is illegal upstream), clear counter, go to LO.
- LO: `SRAM_ADDR`={word,1'b0}; write: drive `write_data[15:0]`, `SRAM_WE_N`=0; read: `SRAM_OE_N`=0, sample `SRAM_DQ` into `read_data[15:0]` on the last phase cycle. After WAIT_CYCLES+1 cycles go to HI.
- HI: same as LO with {word,1'b1} and bits [31:16].
- DONE: `ready`=1 for exactly one cycle, then IDLE unconditionally. Requests still high in DONE do not restart an access.
- word = (`address` − BASE_ADDR)[18:2], modulo 2^32; bits [1:0] ignored; out-of-range addresses wrap silently.
- `ready` is combinational: 1 in IDLE with no request, 1 in DONE, else 0.
- `SRAM_WE_N` is 1 and `SRAM_DQ` is high-Z in IDLE, DONE, and all read phases. `SRAM_OE_N` is 1 during write phases.
- `read_data` holds its value until overwritten by the next read; writes leave it unchanged.

## Timing
- Request first seen in cycle 0 (IDLE). LO spans cycles 1..W+1, HI spans W+2..2W+2, DONE falls in cycle 2W+3 (W=WAIT_CYCLES). With W=1, `ready` is low in cycles 0–4 and high in cycle 5: a 6-cycle access.
- `read_data` is valid in the DONE cycle and is captured by the memory-stage register at that edge.
- Back-to-back: a new request presented in the cycle after DONE starts from IDLE; no dead cycle is added beyond IDLE detection.
- Reset: state IDLE, counter 0, `read_data`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, DQ high-Z. `ready` follows the inputs (1 if no request).
- Reset mid-access aborts at that edge. `SRAM_WE_N` is 1 from the next cycle. A half-written word is not completed.

## Structure
- Shared package: state enum (IDLE/LO/HI/DONE) and the BASE_ADDR default constant.
- No RTL sub-module; the single FSM drives outputs combinationally from state and op.
- The bench supplies a behavioural `sram_model` (256K×16 array, asynchronous read, write on WE_N low).

## Test plan
- Write 0xDEADBEEF at 1024, W=1 → `ready` low 5 cycles, high cycle 5; model[0]=0xBEEF, model[1]=0xDEAD.
- Read 1024 after that → `read_data`=0xDEADBEEF in the DONE cycle; `SRAM_DQ` never driven by the controller.
- Write 0x12345678 at 1028, then read 1028 back-to-back → model[2..3]=0x5678/0x1234; read returns 0x12345678; second access starts in the cycle after DONE.
- W=3, read 1032 → `ready` low exactly 9 cycles; each phase holds `SRAM_ADDR` for 4 cycles.
- `rst`=0 asserted in the HI phase of a write → next cycle state IDLE, `SRAM_WE_N`=1, DQ high-Z; upper half-word of the model is unchanged.
- No request for 10 cycles → `ready`=1 throughout, `SRAM_WE_N`=1, `read_data` stable.
